rom_bank_arbiter: RTL

ROM_BANK_ARBITER -- requirements
Module: rom_bank_arbiter

---
 rtl/rom_arb_pkg.sv | 27 ++
 rtl/rom_arb_decode.sv | 28 ++
 rtl/rom_bank_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg -- shared types and constants for the ROM bank arbiter.
//   arb_state_t   : arbiter FSM states
//   cpu_region_t  : CPU address region classification
//   WIN_LO/WIN_HI : banked window bounds [0x6000, 0x8000)
//   FIXED_OFS     : SDRAM offset of the fixed 32 KB region
//   UNMAPPED_DATA : read data returned for unmapped CPU addresses
package rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_WAIT,
    ST_VID_WAIT,
    ST_ACK
  } arb_state_t;

  typedef enum logic [1:0] {
    RGN_UNMAPPED,
    RGN_WINDOW,
    RGN_FIXED
  } cpu_region_t;

  localparam logic [15:0] WIN_LO        = 16'h6000;
  localparam logic [15:0] WIN_HI        = 16'h8000;
  localparam logic [17:0] FIXED_OFS     = 18'h08000;
  localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

endpackage

// File: rtl/rom_arb_decode.sv
// rom_arb_decode -- combinational CPU address decode and translation.
// Ports:
//   i_cpu_addr [15:0] : CPU byte address
//   i_bs       [1:0]  : current bank select
//   o_region          : unmapped / banked window / fixed region
//   o_offset   [17:0] : SDRAM offset relative to the program ROM base
module rom_arb_decode
  import rom_arb_pkg::*;
(
  input  logic [15:0]  i_cpu_addr,
  input  logic [1:0]   i_bs,
  output cpu_region_t  o_region,
  output logic [17:0]  o_offset
);

  always_comb begin
    o_region = RGN_UNMAPPED;
    o_offset = '0;
    if (i_cpu_addr >= WIN_HI) begin
      o_region = RGN_FIXED;
      o_offset = FIXED_OFS + {3'b000, i_cpu_addr[14:0]};
    end else if (i_cpu_addr >= WIN_LO) begin
      o_region = RGN_WINDOW;
      o_offset = {3'b000, i_bs, i_cpu_addr[12:0]};
    end
  end

endmodule

// File: rtl/rom_bank_arbiter.sv
// rom_bank_arbiter -- arbitrates CPU program reads and video tile fetches
// onto a single SDRAM read port, with bank translation for the CPU window.
// Ports:
//   CLK, RST                : clock, synchronous active-high reset
//   cpu_req/addr/ack/data   : CPU read channel (req held until ack)
//   vid_req/addr/ack/data   : video fetch channel (req held until ack)
//   bs                      : bank select from the protection chip
//   ss_cs, ss_ad            : strobe/address to the protection chip
//   mem_req/addr/rdy/data   : SDRAM read port
// Build option: ROMARB_VID_PRIORITY_EN -- when defined, video wins every tie;
// otherwise ties alternate, starting with the CPU after reset.
//
// state       | meaning
// ST_IDLE     | waiting for a request; grants one requester
// ST_CPU_WAIT | SDRAM read outstanding for the CPU
// ST_VID_WAIT | SDRAM read outstanding for video
// ST_ACK      | ack pulse cycle; no grants
module rom_bank_arbiter
  import rom_arb_pkg::*;
#(
  parameter logic [17:0] PRG_BASE = 18'h00000,
  parameter logic [17:0] CHR_BASE = 18'h20000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic        cpu_ack,
  output logic [7:0]  cpu_data,
  input  logic        vid_req,
  input  logic [16:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_data,
  input  logic [1:0]  bs,
  output logic        ss_cs,
  output logic [12:0] ss_ad,
  output logic        mem_req,
  output logic [17:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_data
);

  arb_state_t  r_state, w_state_nxt;
  logic        w_grant_cpu, w_grant_vid;
  cpu_region_t w_region;
  logic [17:0] w_cpu_ofs;

  logic        r_last_vid;
  logic        r_cpu_ack, r_vid_ack, r_ss_cs, r_mem_req;
  logic [7:0]  r_cpu_data, r_vid_data;
  logic [12:0] r_ss_ad;
  logic [17:0] r_mem_addr;

  rom_arb_decode u_decode (
    .i_cpu_addr (cpu_addr),
    .i_bs       (bs),
    .o_region   (w_region),
    .o_offset   (w_cpu_ofs)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_cpu = 1'b0;
    w_grant_vid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_req && vid_req) begin
`ifdef ROMARB_VID_PRIORITY_EN
          w_grant_vid = 1'b1;
`else
          // Round-robin: favour whoever did not win the previous grant.
          w_grant_cpu = r_last_vid;
          w_grant_vid = !r_last_vid;
`endif
        end else begin
          w_grant_cpu = cpu_req;
          w_grant_vid = vid_req;
        end
        if (w_grant_cpu)
          w_state_nxt = (w_region == RGN_UNMAPPED) ? ST_ACK : ST_CPU_WAIT;
        else if (w_grant_vid)
          w_state_nxt = ST_VID_WAIT;
      end
      ST_CPU_WAIT: if (mem_rdy) w_state_nxt = ST_ACK;
      ST_VID_WAIT: if (mem_rdy) w_state_nxt = ST_ACK;
      ST_ACK:      w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Address and bank are captured only in the grant cycle so a bank switch
  // while the SDRAM read is in flight cannot redirect it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_vid <= 1'b1;
      r_cpu_ack  <= 1'b0;
      r_vid_ack  <= 1'b0;
      r_ss_cs    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_cpu_data <= UNMAPPED_DATA;
      r_vid_data <= UNMAPPED_DATA;
      r_ss_ad    <= '0;
      r_mem_addr <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_vid_ack <= 1'b0;
      r_ss_cs   <= 1'b0;
      if (w_grant_cpu) begin
        r_last_vid <= 1'b0;
        r_ss_ad    <= cpu_addr[12:0];
        if (w_region == RGN_UNMAPPED) begin
          r_cpu_ack  <= 1'b1;
          r_cpu_data <= UNMAPPED_DATA;
        end else begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= PRG_BASE + w_cpu_ofs;
          r_ss_cs    <= (w_region == RGN_WINDOW);
        end
      end
      if (w_grant_vid) begin
        r_last_vid <= 1'b1;
        r_mem_req  <= 1'b1;
        r_mem_addr <= CHR_BASE + {1'b0, vid_addr};
      end
      if (mem_rdy && r_state == ST_CPU_WAIT) begin
        r_mem_req  <= 1'b0;
        r_cpu_data <= mem_data;
        r_cpu_ack  <= 1'b1;
      end
      if (mem_rdy && r_state == ST_VID_WAIT) begin
        r_mem_req  <= 1'b0;
        r_vid_data <= mem_data;
        r_vid_ack  <= 1'b1;
      end
    end
  end

  assign cpu_ack  = r_cpu_ack;
  assign cpu_data = r_cpu_data;
  assign vid_ack  = r_vid_ack;
  assign vid_data = r_vid_data;
  assign ss_cs    = r_ss_cs;
  assign ss_ad    = r_ss_ad;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

endmodule
